arb_req_stage: RTL and testbench

ARB_REQ_STAGE -- requirements
Module: arb_req_stage

---
 rtl/arb_req_stage.sv | 198 +++++++++++++++++++
 tb/tb_arb_req_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_stage.sv
// arb_req_stage
// Front-end stage between request-event sources and a downstream arbiter.
// Each channel turns one-cycle request pulses into a pending count and
// raises a level request toward the arbiter while it is waiting for a
// grant. A rising edge on the channel's grant retires one pending request.
// The two channels are independent, identical copies of this logic.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req_in[1:0] in   request event pulses, one bit per channel
//   gnt_0       in   channel-0 grant level from the arbiter
//   gnt_1       in   channel-1 grant level from the arbiter
//   clr_err     in   clears the sticky ovf and spur flags
//   req_out     out  registered request level, high while a channel is PEND
//   pend_cnt_0  out  channel-0 pending request count
//   pend_cnt_1  out  channel-1 pending request count
//   ovf         out  sticky: a request pulse was dropped at a full counter
//   spur        out  sticky: a grant edge arrived while the channel was not PEND
//   starve      out  channel has waited STARVE_LIM or more cycles in PEND
module arb_req_stage #(
  parameter int CNT_W      = 3,
  parameter int STARVE_LIM = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_in,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             clr_err,
  output logic [1:0]       req_out,
  output logic [CNT_W-1:0] pend_cnt_0,
  output logic [CNT_W-1:0] pend_cnt_1,
  output logic [1:0]       ovf,
  output logic [1:0]       spur,
  output logic [1:0]       starve
);

  // Wait counter is just wide enough to hold STARVE_LIM.
  localparam int WAIT_W = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(STARVE_LIM);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  // One-hot channel states.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_PEND = 3'b010;
  localparam logic [2:0] S_SERV = 3'b100;

  logic [1:0]             gnt;
  logic [1:0]             gnt_d;
  logic [1:0]             gnt_ev;
  logic [1:0]             take;
  logic [1:0]             drop;

  logic [1:0][2:0]        state;
  logic [1:0][2:0]        state_nx;
  logic [1:0][CNT_W-1:0]  cnt;
  logic [1:0][CNT_W-1:0]  cnt_nx;
  logic [1:0][WAIT_W-1:0] wait_cnt;
  logic [1:0][WAIT_W-1:0] wait_nx;

  logic [1:0]             req_nx;
  logic [1:0]             ovf_nx;
  logic [1:0]             spur_nx;
  logic [1:0]             starve_nx;

  assign gnt        = {gnt_1, gnt_0};
  assign pend_cnt_0 = cnt[0];
  assign pend_cnt_1 = cnt[1];

  // Grant edge detection and the per-channel event terms that drive the FSM.
  always_comb begin
    gnt_ev = 2'b00;
    take   = 2'b00;
    drop   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      gnt_ev[i] = gnt[i] & ~gnt_d[i];
      // Only a grant edge seen in PEND retires a request.
      take[i]   = gnt_ev[i] & (state[i] == S_PEND);
      // A pulse into a full counter is lost unless a retire offsets it.
      drop[i]   = req_in[i] & ~take[i] & (cnt[i] == CNT_MAX);
    end
  end

  // Next-state logic: pending count, channel FSM and wait counter.
  always_comb begin
    cnt_nx   = cnt;
    state_nx = state;
    wait_nx  = wait_cnt;
    for (int i = 0; i < 2; i++) begin
      // Count: +1 per pulse, -1 per retire, saturating at both ends.
      if (req_in[i] && take[i]) begin
        cnt_nx[i] = cnt[i];
      end else if (req_in[i]) begin
        if (cnt[i] == CNT_MAX) begin
          cnt_nx[i] = cnt[i];
        end else begin
          cnt_nx[i] = cnt[i] + CNT_ONE;
        end
      end else if (take[i]) begin
        if (cnt[i] == CNT_ZERO) begin
          cnt_nx[i] = cnt[i];
        end else begin
          cnt_nx[i] = cnt[i] - CNT_ONE;
        end
      end else begin
        cnt_nx[i] = cnt[i];
      end

      // FSM. Decisions on "count > 0" look at the updated count so a pulse
      // arriving on the deciding cycle is not stranded in IDLE.
      case (state[i])
        S_IDLE: begin
          if (cnt_nx[i] != CNT_ZERO) begin
            state_nx[i] = S_PEND;
          end else begin
            state_nx[i] = S_IDLE;
          end
        end
        S_PEND: begin
          if (take[i]) begin
            state_nx[i] = S_SERV;
          end else begin
            state_nx[i] = S_PEND;
          end
        end
        S_SERV: begin
          if (gnt[i]) begin
            state_nx[i] = S_SERV;
          end else if (cnt_nx[i] != CNT_ZERO) begin
            state_nx[i] = S_PEND;
          end else begin
            state_nx[i] = S_IDLE;
          end
        end
        default: begin
          // Illegal encoding: fall back to IDLE.
          state_nx[i] = S_IDLE;
        end
      endcase

      // Wait counter runs only while the channel stays in PEND.
      if ((state[i] == S_PEND) && (state_nx[i] == S_PEND)) begin
        if (wait_cnt[i] == WAIT_LIM) begin
          wait_nx[i] = wait_cnt[i];
        end else begin
          wait_nx[i] = wait_cnt[i] + WAIT_ONE;
        end
      end else begin
        wait_nx[i] = WAIT_ZERO;
      end
    end
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    req_nx    = 2'b00;
    ovf_nx    = 2'b00;
    spur_nx   = 2'b00;
    starve_nx = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_nx[i]    = (state_nx[i] == S_PEND);
      // A set event wins over a same-cycle clear.
      ovf_nx[i]    = drop[i] | (ovf[i] & ~clr_err);
      spur_nx[i]   = (gnt_ev[i] & (state[i] != S_PEND)) | (spur[i] & ~clr_err);
      starve_nx[i] = (wait_nx[i] == WAIT_LIM);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= {S_IDLE, S_IDLE};
      cnt      <= {CNT_ZERO, CNT_ZERO};
      wait_cnt <= {WAIT_ZERO, WAIT_ZERO};
      gnt_d    <= 2'b00;
      req_out  <= 2'b00;
      ovf      <= 2'b00;
      spur     <= 2'b00;
      starve   <= 2'b00;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wait_cnt <= wait_nx;
      gnt_d    <= gnt;
      req_out  <= req_nx;
      ovf      <= ovf_nx;
      spur     <= spur_nx;
      starve   <= starve_nx;
    end
  end

endmodule

// File: tb/tb_arb_req_stage.sv
// Self-checking bench for arb_req_stage: directed scenarios with constant
// expectations, then randomized traffic checked every cycle against a
// behavioural reference model of the pending-request rules.
module tb_arb_req_stage;

  localparam int MAXC = 7;
  localparam int LIM  = 15;

  logic       clock;
  logic       reset;
  logic [1:0] req_in;
  logic       gnt_0;
  logic       gnt_1;
  logic       clr_err;
  logic [1:0] req_out;
  logic [2:0] pend_cnt_0;
  logic [2:0] pend_cnt_1;
  logic [1:0] ovf;
  logic [1:0] spur;
  logic [1:0] starve;

  int checks = 0;
  int errors = 0;

  // Reference model: count as a plain integer, mode 0=idle 1=waiting 2=served.
  int m_cnt  [2];
  int m_mode [2];
  int m_wait [2];
  bit m_gd   [2];
  bit m_ovf  [2];
  bit m_spur [2];

  arb_req_stage dut (
    .clock      (clock),
    .reset      (reset),
    .req_in     (req_in),
    .gnt_0      (gnt_0),
    .gnt_1      (gnt_1),
    .clr_err    (clr_err),
    .req_out    (req_out),
    .pend_cnt_0 (pend_cnt_0),
    .pend_cnt_1 (pend_cnt_1),
    .ovf        (ovf),
    .spur       (spur),
    .starve     (starve)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [13:0] dut_vec = {req_out, pend_cnt_1, pend_cnt_0, ovf, spur, starve};

  function automatic logic [13:0] model_vec();
    logic [2:0] c0;
    logic [2:0] c1;
    c0 = 3'(m_cnt[0]);
    c1 = 3'(m_cnt[1]);
    return {(m_mode[1] == 1), (m_mode[0] == 1), c1, c0,
            m_ovf[1], m_ovf[0], m_spur[1], m_spur[0],
            (m_wait[1] == LIM), (m_wait[0] == LIM)};
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [1:0] r, input bit g0, input bit g1,
                            input bit clr, input bit rst);
    for (int ch = 0; ch < 2; ch++) begin
      bit g, ev, was_pend, take, set_ovf, set_spur;
      int n, nm;
      g = (ch == 0) ? g0 : g1;
      if (rst) begin
        m_cnt[ch] = 0; m_mode[ch] = 0; m_wait[ch] = 0;
        m_gd[ch] = 0; m_ovf[ch] = 0; m_spur[ch] = 0;
      end else begin
        ev       = g && !m_gd[ch];
        was_pend = (m_mode[ch] == 1);
        take     = ev && was_pend;
        n        = m_cnt[ch] + int'(r[ch]) - int'(take);
        set_ovf  = 0;
        if (n > MAXC) begin n = MAXC; set_ovf = 1; end
        if (n < 0) n = 0;
        set_spur = ev && !was_pend;
        case (m_mode[ch])
          0:       nm = (n > 0) ? 1 : 0;
          1:       nm = take ? 2 : 1;
          default: nm = g ? 2 : ((n > 0) ? 1 : 0);
        endcase
        if (was_pend && nm == 1) m_wait[ch] = (m_wait[ch] + 1 > LIM) ? LIM : m_wait[ch] + 1;
        else m_wait[ch] = 0;
        m_ovf[ch]  = set_ovf  || (m_ovf[ch]  && !clr);
        m_spur[ch] = set_spur || (m_spur[ch] && !clr);
        m_gd[ch]   = g;
        m_cnt[ch]  = n;
        m_mode[ch] = nm;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past the edge.
  task automatic drive_cycle(input logic [1:0] r, input bit g0, input bit g1,
                             input bit clr, input bit rst);
    req_in = r; gnt_0 = g0; gnt_1 = g1; clr_err = clr; reset = rst;
    @(posedge clock);
    model_step(r, g0, g1, clr, rst);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_vec !== 14'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 14'h0);
    end
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (req_out !== 2'b00) begin
      errors++; $display("FAIL reset_quiet: req_out got %b expected 00", req_out);
    end
  endtask

  task automatic test_single_grant();
    drive_cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (req_out !== 2'b01 || pend_cnt_0 !== 3'd1) begin
      errors++; $display("FAIL single_req: req_out %b cnt0 %0d expected 01 1", req_out, pend_cnt_0);
    end
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (req_out !== 2'b00 || pend_cnt_0 !== 3'd0) begin
      errors++; $display("FAIL single_grant: req_out %b cnt0 %0d expected 00 0", req_out, pend_cnt_0);
    end
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (req_out !== 2'b00 || spur !== 2'b00 || pend_cnt_0 !== 3'd0) begin
      errors++; $display("FAIL single_release: req_out %b spur %b cnt0 %0d expected 00 00 0",
                         req_out, spur, pend_cnt_0);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) drive_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pend_cnt_1 !== 3'd7 || ovf !== 2'b10 || req_out !== 2'b10) begin
      errors++; $display("FAIL overflow: cnt1 %0d ovf %b req %b expected 7 10 10",
                         pend_cnt_1, ovf, req_out);
    end
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf !== 2'b00 || pend_cnt_1 !== 3'd7) begin
      errors++; $display("FAIL overflow_clear: ovf %b cnt1 %0d expected 00 7", ovf, pend_cnt_1);
    end
  endtask

  task automatic test_simultaneous();
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pend_cnt_0 !== 3'd2 || req_out[0] !== 1'b0) begin
      errors++; $display("FAIL simul_grant: cnt0 %0d req0 %b expected 2 0", pend_cnt_0, req_out[0]);
    end
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pend_cnt_0 !== 3'd2 || req_out[0] !== 1'b1) begin
      errors++; $display("FAIL simul_release: cnt0 %0d req0 %b expected 2 1", pend_cnt_0, req_out[0]);
    end
  endtask

  task automatic test_spurious();
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_cycle(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (spur !== 2'b10 || pend_cnt_1 !== 3'd0 || req_out !== 2'b00) begin
      errors++; $display("FAIL spur_idle: spur %b cnt1 %0d req %b expected 10 0 00",
                         spur, pend_cnt_1, req_out);
    end
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (spur !== 2'b10) begin
      errors++; $display("FAIL spur_set_priority: spur %b expected 10", spur);
    end
    drive_cycle(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (spur !== 2'b00) begin
      errors++; $display("FAIL spur_clear: spur %b expected 00", spur);
    end
  endtask

  task automatic test_starve();
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (starve !== 2'b00) begin
      errors++; $display("FAIL starve_early: starve %b expected 00", starve);
    end
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (starve !== 2'b01) begin
      errors++; $display("FAIL starve_set: starve %b expected 01", starve);
    end
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (starve !== 2'b00 || req_out !== 2'b00) begin
      errors++; $display("FAIL starve_clear: starve %b req %b expected 00 00", starve, req_out);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive_cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pend_cnt_0 !== 3'd3 || pend_cnt_1 !== 3'd2 || req_out !== 2'b01) begin
      errors++; $display("FAIL mid_setup: cnt0 %0d cnt1 %0d req %b expected 3 2 01",
                         pend_cnt_0, pend_cnt_1, req_out);
    end
    drive_cycle(2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (dut_vec !== 14'h0) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", dut_vec, 14'h0);
    end
    for (int k = 0; k < 4; k++) drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (req_out !== 2'b00 || pend_cnt_0 !== 3'd0 || pend_cnt_1 !== 3'd0) begin
      errors++; $display("FAIL mid_after: req %b cnt0 %0d cnt1 %0d expected 00 0 0",
                         req_out, pend_cnt_0, pend_cnt_1);
    end
  endtask

  task automatic test_random();
    bit g0 = 1'b0;
    bit g1 = 1'b0;
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] r;
      bit clr, rst;
      r[0] = ($urandom_range(0, 2) == 0);
      r[1] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) g0 = ~g0;
      if ($urandom_range(0, 3) == 0) g1 = ~g1;
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 249) == 0);
      drive_cycle(r, g0, g1, clr, rst);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", k, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    req_in = 2'b00; gnt_0 = 1'b0; gnt_1 = 1'b0; clr_err = 1'b0; reset = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      m_cnt[ch] = 0; m_mode[ch] = 0; m_wait[ch] = 0;
      m_gd[ch] = 0; m_ovf[ch] = 0; m_spur[ch] = 0;
    end
    @(negedge clock);
    test_reset();
    test_single_grant();
    test_overflow();
    test_simultaneous();
    test_spurious();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
